// File: rtl/rtc_scan_sequencer_pkg.sv
// Shared definitions for the RTC scan sequencer: FSM states, register count, address map.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package rtc_scan_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_CAP,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE
  } state_t;

  localparam int RTC_NUM_REGS = 10;
  localparam int RTC_DOW_IDX  = 6;
  localparam int TMO_W        = 8;
  localparam logic [3:0] ADDR_NONE = 4'd15;

  // Local register index -> physical RTC register address.
  function automatic logic [7:0] rtc_phys_addr(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      4'd0:    a = 8'h21;  // seconds
      4'd1:    a = 8'h22;  // minutes
      4'd2:    a = 8'h23;  // hours
      4'd3:    a = 8'h24;  // day
      4'd4:    a = 8'h25;  // month
      4'd5:    a = 8'h26;  // year
      4'd6:    a = 8'h27;  // day of week
      4'd7:    a = 8'h41;  // timer seconds
      4'd8:    a = 8'h42;  // timer minutes
      4'd9:    a = 8'h43;  // timer hours
      default: a = 8'h00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_bus_timeout.sv
// Watchdog for an outstanding RTC bus transaction: counts wait cycles, flags expiry.
// Latency: o_expired asserts combinationally in the TIMEOUT_CYC-th wait cycle.
// Backpressure: none; counter saturates at the limit until cleared.
module rtc_bus_timeout
  import rtc_scan_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expired
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] r_cnt;

  // Count wait cycles; restart at every new request, hold once the limit is hit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_run && (r_cnt == LIMIT);

endmodule

// File: rtl/rtc_scan_sequencer.sv
// Sequences RTC register read scans and interleaved single writes over a req/ack bus.
// Latency: bus_req rises 2 cycles after a start; capture strobe 1 cycle after bus_ack.
// Backpressure: waits on bus_ack up to TIMEOUT_CYC cycles, then aborts with bus_err.
module rtc_scan_sequencer
  import rtc_scan_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int NUM_REGS    = RTC_NUM_REGS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scan_start,
  input  logic       wr_req,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       bus_req,
  output logic       bus_rnw,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic       bus_ack,
  input  logic [7:0] bus_rdata,
  output logic [3:0] addr_mem_local,
  output logic [7:0] dato_rtc,
  output logic       dato_valid,
  output logic       busy,
  output logic       scan_done,
  output logic       bus_err
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

  state_t     r_state, w_nxt_state;
  logic [3:0] r_idx, w_nxt_idx;
  logic       r_in_scan, w_nxt_in_scan;
  logic       r_scan_pend, w_nxt_pend;
  logic       r_bus_req, w_nxt_bus_req;
  logic       r_bus_rnw, w_nxt_bus_rnw;
  logic [7:0] r_bus_addr, w_nxt_bus_addr;
  logic [7:0] r_bus_wdata, w_nxt_bus_wdata;
  logic       r_wr_ack, w_nxt_wr_ack;
  logic [3:0] r_local, w_nxt_local;
  logic [7:0] r_dato_rtc, w_nxt_dato;
  logic       r_dato_vld, w_nxt_dato_vld;
  logic       r_done, w_nxt_done;
  logic       r_bus_err, w_nxt_err;

  logic w_wr_vld, w_wr_bad, w_tmo, w_tmr_clr, w_tmr_run;

  // The requester still holds wr_req during the ack cycle, so ignore it then.
  assign w_wr_vld  = wr_req && !r_wr_ack;
  // Out-of-range and day-of-week writes complete without touching the bus.
  assign w_wr_bad  = ({1'b0, wr_addr} >= 5'(NUM_REGS)) || (wr_addr == 4'(RTC_DOW_IDX));
  assign w_tmr_clr = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);
  assign w_tmr_run = (r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT);

  rtc_bus_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clr     (w_tmr_clr),
    .i_run     (w_tmr_run),
    .o_expired (w_tmo)
  );

  // Next-state and next-output decode; all outputs are registered from these.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_idx       = r_idx;
    w_nxt_in_scan   = r_in_scan;
    w_nxt_pend      = r_scan_pend | scan_start;
    w_nxt_bus_req   = r_bus_req;
    w_nxt_bus_rnw   = r_bus_rnw;
    w_nxt_bus_addr  = r_bus_addr;
    w_nxt_bus_wdata = r_bus_wdata;
    w_nxt_wr_ack    = 1'b0;
    w_nxt_local     = ADDR_NONE;
    w_nxt_dato      = r_dato_rtc;
    w_nxt_dato_vld  = 1'b0;
    w_nxt_done      = 1'b0;
    w_nxt_err       = r_bus_err & ~scan_start;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_vld) begin
          w_nxt_state   = ST_WR_REQ;
          w_nxt_in_scan = 1'b0;
        end else if (r_scan_pend || scan_start) begin
          w_nxt_state   = ST_RD_REQ;
          w_nxt_idx     = 4'd0;
          w_nxt_pend    = 1'b0;
          w_nxt_in_scan = 1'b1;
        end
      end
      ST_RD_REQ: begin
        w_nxt_bus_req  = 1'b1;
        w_nxt_bus_rnw  = 1'b1;
        w_nxt_bus_addr = rtc_phys_addr(r_idx);
        w_nxt_state    = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (bus_ack) begin
          w_nxt_bus_req  = 1'b0;
          w_nxt_dato     = bus_rdata;
          w_nxt_local    = r_idx;
          w_nxt_dato_vld = 1'b1;
          w_nxt_state    = ST_RD_CAP;
        end else if (w_tmo) begin
          w_nxt_bus_req = 1'b0;
          w_nxt_err     = 1'b1;
          w_nxt_in_scan = 1'b0;
          w_nxt_state   = ST_IDLE;
        end
      end
      ST_RD_CAP: begin
        if (r_idx == LAST_IDX) begin
          w_nxt_done  = 1'b1;
          w_nxt_state = ST_DONE;
        end else begin
          w_nxt_idx   = r_idx + 4'd1;
          w_nxt_state = w_wr_vld ? ST_WR_REQ : ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        if (w_wr_bad) begin
          w_nxt_wr_ack = 1'b1;
          w_nxt_state  = r_in_scan ? ST_RD_REQ : ST_IDLE;
        end else begin
          w_nxt_bus_req   = 1'b1;
          w_nxt_bus_rnw   = 1'b0;
          w_nxt_bus_addr  = rtc_phys_addr(wr_addr);
          w_nxt_bus_wdata = wr_data;
          w_nxt_state     = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (bus_ack) begin
          w_nxt_bus_req = 1'b0;
          w_nxt_wr_ack  = 1'b1;
          w_nxt_state   = r_in_scan ? ST_RD_REQ : ST_IDLE;
        end else if (w_tmo) begin
          w_nxt_bus_req = 1'b0;
          w_nxt_wr_ack  = 1'b1;
          w_nxt_err     = 1'b1;
          w_nxt_in_scan = 1'b0;
          w_nxt_state   = ST_IDLE;
        end
      end
      ST_DONE: begin
        w_nxt_in_scan = 1'b0;
        w_nxt_state   = ST_IDLE;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // State and output registers; reset parks everything idle with the demux index parked at 15.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= 4'd0;
      r_in_scan   <= 1'b0;
      r_scan_pend <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_rnw   <= 1'b0;
      r_bus_addr  <= 8'd0;
      r_bus_wdata <= 8'd0;
      r_wr_ack    <= 1'b0;
      r_local     <= ADDR_NONE;
      r_dato_rtc  <= 8'd0;
      r_dato_vld  <= 1'b0;
      r_done      <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_idx       <= w_nxt_idx;
      r_in_scan   <= w_nxt_in_scan;
      r_scan_pend <= w_nxt_pend;
      r_bus_req   <= w_nxt_bus_req;
      r_bus_rnw   <= w_nxt_bus_rnw;
      r_bus_addr  <= w_nxt_bus_addr;
      r_bus_wdata <= w_nxt_bus_wdata;
      r_wr_ack    <= w_nxt_wr_ack;
      r_local     <= w_nxt_local;
      r_dato_rtc  <= w_nxt_dato;
      r_dato_vld  <= w_nxt_dato_vld;
      r_done      <= w_nxt_done;
      r_bus_err   <= w_nxt_err;
    end
  end

  assign wr_ack         = r_wr_ack;
  assign bus_req        = r_bus_req;
  assign bus_rnw        = r_bus_rnw;
  assign bus_addr       = r_bus_addr;
  assign bus_wdata      = r_bus_wdata;
  assign addr_mem_local = r_local;
  assign dato_rtc       = r_dato_rtc;
  assign dato_valid     = r_dato_vld;
  assign busy           = (r_state != ST_IDLE);
  assign scan_done      = r_done;
  assign bus_err        = r_bus_err;

endmodule

// File: tb/tb_rtc_scan_sequencer.sv
// Scoreboard bench for rtc_scan_sequencer with a modelled RTC bus driver.
// Latency: bus driver acks 3 cycles after each bus_req rise unless told to stall.
// Backpressure: stalled addresses never ack, exercising the timeout path.
module tb_rtc_scan_sequencer;

  localparam logic [7:0] EV_RD   = 8'h01;
  localparam logic [7:0] EV_WR   = 8'h02;
  localparam logic [7:0] EV_ACK  = 8'h03;
  localparam logic [7:0] EV_DONE = 8'h04;
  localparam logic [7:0] PHYS [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                                       8'h26, 8'h27, 8'h41, 8'h42, 8'h43};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scan_start, wr_req, bus_ack;
  logic [3:0] wr_addr;
  logic [7:0] wr_data, bus_rdata;
  logic       wr_ack, bus_req, bus_rnw, dato_valid, busy, scan_done, bus_err;
  logic [7:0] bus_addr, bus_wdata, dato_rtc;
  logic [3:0] addr_mem_local;

  int         n_vec = 0;
  int         n_err = 0;
  int         bus_txn_cnt = 0;
  logic [7:0] stall_addr = 8'hFF;
  logic [23:0] sb_q[$];

  always #5 clk = ~clk;

  rtc_scan_sequencer dut (
    .clk(clk), .reset_n(reset_n), .scan_start(scan_start),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .bus_req(bus_req), .bus_rnw(bus_rnw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .addr_mem_local(addr_mem_local), .dato_rtc(dato_rtc), .dato_valid(dato_valid),
    .busy(busy), .scan_done(scan_done), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [23:0] got);
    logic [23:0] e;
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 24'hFFFFFF;
    chk(tag, 32'(got), 32'(e));
  endtask

  task automatic push_reads(input int first, input int last);
    for (int i = first; i <= last; i++) sb_q.push_back({EV_RD, 4'h0, 4'(i), 8'h10 + 8'(i)});
  endtask

  task automatic push_scan();
    push_reads(0, 9);
    sb_q.push_back({EV_DONE, 16'h0});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_scan();
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) break;
    end
    chk(tag, {busy, 31'(sb_q.size())}, 32'd0);
  endtask

  task automatic wait_req(input string tag, input logic [7:0] a);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus_req && bus_addr == a) break;
    end
    chk(tag, {bus_req, bus_addr}, {1'b1, a});
  endtask

  // Drives one write request and drops it once wr_ack is seen; reports cycles to ack.
  task automatic wr_txn(input logic [3:0] a, input logic [7:0] d, input logic with_scan,
                        output int lat);
    wr_addr = a; wr_data = d; wr_req = 1'b1; scan_start = with_scan; lat = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      scan_start = 1'b0;
      lat++;
      if (wr_ack) break;
    end
    chk("wr_ack_seen", wr_ack, 1);
    wr_req = 1'b0;
  endtask

  // RTC bus driver model: ack 3 cycles after bus_req rises, rdata = 0x10 + local index.
  initial begin
    int wcnt;
    logic given;
    wcnt = 0; given = 1'b0;
    bus_ack = 1'b0; bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (!bus_req) begin
        wcnt = 0; given = 1'b0;
      end else if (!given && bus_addr != stall_addr) begin
        if (wcnt == 2) begin
          bus_ack = 1'b1;
          given = 1'b1;
          bus_rdata = 8'hEE;
          for (int k = 0; k < 10; k++) if (PHYS[k] == bus_addr) bus_rdata = 8'h10 + 8'(k);
        end
        wcnt++;
      end
    end
  end

  // Output monitor: every observed event is matched against the scoreboard head.
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (dato_valid) sb_pop("dato", {EV_RD, 4'h0, addr_mem_local, dato_rtc});
      if (bus_req && !prev_req) begin
        bus_txn_cnt++;
        if (!bus_rnw) sb_pop("bus_wr", {EV_WR, bus_addr, bus_wdata});
      end
      if (wr_ack) sb_pop("wr_ack", {EV_ACK, 16'h0});
      if (scan_done) sb_pop("scan_done", {EV_DONE, 16'h0});
      prev_req = bus_req;
    end
  end

  initial begin
    int lat, cnt, txn0;
    reset_n = 1'b0; scan_start = 1'b0; wr_req = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
    tick(3);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_local", addr_mem_local, 15);
    chk("rst_err", bus_err, 0);
    chk("rst_dvld", dato_valid, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_done", scan_done, 0);
    reset_n = 1'b1;
    tick(2);

    // Full read scan.
    push_scan();
    pulse_scan();
    wait_quiet("scan_a");
    chk("scan_a_err", bus_err, 0);

    // Write arriving during the index-3 read is serviced between reads 3 and 4.
    push_reads(0, 3);
    sb_q.push_back({EV_WR, 8'h42, 8'h45});
    sb_q.push_back({EV_ACK, 16'h0});
    push_reads(4, 9);
    sb_q.push_back({EV_DONE, 16'h0});
    pulse_scan();
    wait_req("wait_idx3", 8'h24);
    wr_txn(4'd8, 8'h45, 1'b0, lat);
    wait_quiet("scan_wr");

    // Timeout at index 5: bus_req held exactly TIMEOUT_CYC cycles, abort, sticky error.
    stall_addr = 8'h26;
    push_reads(0, 4);
    pulse_scan();
    wait_req("wait_idx5", 8'h26);
    cnt = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus_req) break;
      cnt++;
    end
    chk("tmo_len", cnt, 255);
    tick(2);
    chk("tmo_err", bus_err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_q", sb_q.size(), 0);
    stall_addr = 8'hFF;
    push_scan();
    pulse_scan();
    chk("err_clr", bus_err, 0);
    wait_quiet("scan_after_tmo");

    // Write and scan_start together in IDLE: write first, then the scan.
    sb_q.push_back({EV_WR, 8'h23, 8'h77});
    sb_q.push_back({EV_ACK, 16'h0});
    push_scan();
    wr_txn(4'd2, 8'h77, 1'b1, lat);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dato_valid && addr_mem_local == 4'd2) break;
    end
    chk("wait_dato2", {dato_valid, addr_mem_local}, {1'b1, 4'd2});
    // Two pulses mid-scan collapse into a single extra scan.
    push_scan();
    pulse_scan();
    tick(5);
    pulse_scan();
    wait_quiet("scan_pend");
    tick(60);
    chk("no_third_scan", {busy, 31'(sb_q.size())}, 32'd0);

    // Writes to the unused and out-of-range indices ack without any bus traffic.
    txn0 = bus_txn_cnt;
    sb_q.push_back({EV_ACK, 16'h0});
    wr_txn(4'd6, 8'h55, 1'b0, lat);
    chk("wr6_lat", lat, 2);
    tick(2);
    sb_q.push_back({EV_ACK, 16'h0});
    wr_txn(4'd12, 8'h66, 1'b0, lat);
    chk("wr12_lat", lat, 2);
    tick(3);
    chk("bad_wr_no_bus", bus_txn_cnt, txn0);

    // Asynchronous reset while the index-7 read is outstanding.
    stall_addr = 8'h41;
    push_reads(0, 6);
    pulse_scan();
    wait_req("wait_idx7", 8'h41);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_bus_req", bus_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_local", addr_mem_local, 15);
    tick(2);
    reset_n = 1'b1;
    stall_addr = 8'hFF;
    tick(40);
    chk("post_rst_q", sb_q.size(), 0);
    chk("post_rst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
